// File: rtl/magic_packet_checker.sv
// Monitor for a FIFO under test: tracks occupancy, follows one captured "magic"
// packet to the FIFO output and checks its data, and flags overflow/underflow.
module magic_packet_checker #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int CNTWID = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              capture,
    input  logic              rearm,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [WIDTH-1:0]  data_out,
    output logic [CNTWID-1:0] occ,
    output logic [CNTWID-1:0] cnt,
    output logic [1:0]        state,
    output logic [WIDTH-1:0]  magic_data,
    output logic              done,
    output logic              mismatch,
    output logic              overflow,
    output logic              underflow
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        TRACKING = 2'b01,
        DONE     = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [CNTWID-1:0] occ_q, occ_d;
    logic [CNTWID-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  magic_q, magic_d;
    logic              done_q, done_d;
    logic              mismatch_q, mismatch_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic full, empty, push_acc, pop_acc;

    always_comb begin
        full     = (occ_q == CNTWID'(DEPTH));
        empty    = (occ_q == '0);
        // A push while full only fits if a pop frees the slot in the same cycle.
        push_acc = push && !(full && !pop);
        pop_acc  = pop && !empty;
        occ_d    = occ_q + CNTWID'(push_acc) - CNTWID'(pop_acc);

        state_d     = state_q;
        cnt_d       = cnt_q;
        magic_d     = magic_q;
        done_d      = 1'b0;
        mismatch_d  = mismatch_q;
        overflow_d  = overflow_q | (push && full && !pop);
        underflow_d = underflow_q | (pop && empty);

        case (state_q)
            IDLE: begin
                cnt_d = occ_d;
                if (capture && push_acc) begin
                    magic_d = data_in;
                    cnt_d   = occ_q - CNTWID'(pop_acc);
                    state_d = TRACKING;
                end
            end
            TRACKING: begin
                if (pop_acc) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        done_d     = 1'b1;
                        mismatch_d = mismatch_q | (data_out != magic_q);
                        cnt_d      = '0;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                cnt_d = '0;
                if (rearm) begin
                    cnt_d   = occ_d;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            occ_q       <= '0;
            cnt_q       <= '0;
            magic_q     <= '0;
            done_q      <= 1'b0;
            mismatch_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            cnt_q       <= cnt_d;
            magic_q     <= magic_d;
            done_q      <= done_d;
            mismatch_q  <= mismatch_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign occ        = occ_q;
    assign cnt        = cnt_q;
    assign state      = state_q;
    assign magic_data = magic_q;
    assign done       = done_q;
    assign mismatch   = mismatch_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_magic_packet_checker.sv
// Bench for magic_packet_checker: directed scenarios plus random traffic checked
// against a queue-based model of the FIFO contents with the magic entry tagged.
module tb_magic_packet_checker;

    localparam int DEPTH  = 8;
    localparam int WIDTH  = 8;
    localparam int CNTWID = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst, push, pop, capture, rearm;
    logic [WIDTH-1:0]  data_in, data_out;
    logic [CNTWID-1:0] occ, cnt;
    logic [1:0]        state;
    logic [WIDTH-1:0]  magic_data;
    logic              done, mismatch, overflow, underflow;

    int n_assert = 0;
    int n_fail   = 0;

    magic_packet_checker #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNTWID(CNTWID)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .capture(capture), .rearm(rearm),
        .data_in(data_in), .data_out(data_out), .occ(occ), .cnt(cnt), .state(state),
        .magic_data(magic_data), .done(done), .mismatch(mismatch),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Model: queue entries are {tag, data}; tag marks the magic packet.
    logic [WIDTH:0]   mq[$];
    int               m_state;
    logic [WIDTH-1:0] m_magic;
    logic             m_done, m_mis, m_ovf, m_udf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] front();
        return (mq.size() > 0) ? mq[0][WIDTH-1:0] : '0;
    endfunction

    function automatic int exp_cnt();
        if (m_state == 0) return mq.size();
        if (m_state == 2) return 0;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i][WIDTH]) return i;
        return -1;
    endfunction

    task automatic model(input logic r, pu, po, ca, re, input logic [WIDTH-1:0] di, dout);
        int st0;
        logic [WIDTH:0] item;
        bit full, empty, pa, pacc;
        if (r) begin
            mq.delete();
            m_state = 0; m_magic = '0; m_done = 0; m_mis = 0; m_ovf = 0; m_udf = 0;
            return;
        end
        st0   = m_state;
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        pa    = po && !empty;
        pacc  = pu && !(full && !po);
        if (pu && full && !po) m_ovf = 1;
        if (po && empty) m_udf = 1;
        m_done = 0;
        if (pa) begin
            item = mq.pop_front();
            if (item[WIDTH] && st0 == 1) begin
                m_done = 1;
                if (dout != m_magic) m_mis = 1;
                m_state = 2;
            end
        end
        if (pacc) begin
            mq.push_back({(st0 == 0 && ca), di});
            if (st0 == 0 && ca) begin
                m_magic = di;
                m_state = 1;
            end
        end
        if (st0 == 2 && re) m_state = 0;
    endtask

    task automatic step(input logic r, pu, po, ca, re, input logic [WIDTH-1:0] di, dout);
        rst = r; push = pu; pop = po; capture = ca; rearm = re;
        data_in = di; data_out = dout;
        @(posedge clk);
        model(r, pu, po, ca, re, di, dout);
        #1;
        check("occ", occ, mq.size());
        check("cnt", cnt, exp_cnt());
        check("state", state, m_state);
        check("magic_data", magic_data, m_magic);
        check("done", done, m_done);
        check("mismatch", mismatch, m_mis);
        check("overflow", overflow, m_ovf);
        check("underflow", underflow, m_udf);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic do_push(input logic [WIDTH-1:0] d);
        step(0, 1, 0, 0, 0, d, 8'h00);
    endtask

    task automatic do_pop();
        step(0, 0, 1, 0, 0, 8'h00, front());
    endtask

    task automatic basic_seq(input logic [WIDTH-1:0] exit_data);
        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        do_push(8'h11); do_push(8'h22); do_push(8'h33);
        step(0, 1, 0, 1, 0, 8'h5A, 8'h00);
        check("tp_occ4", occ, 4); check("tp_cnt3", cnt, 3);
        check("tp_trk", state, 2'b01); check("tp_magic", magic_data, 8'h5A);
        do_push(8'h44); do_push(8'h55);
        check("tp_cnt3b", cnt, 3); check("tp_occ6", occ, 6);
        do_pop(); do_pop(); do_pop();
        check("tp_cnt0", cnt, 0);
        step(0, 0, 1, 0, 0, 8'h00, exit_data);
        check("tp_done", done, 1); check("tp_mis", mismatch, exit_data != 8'h5A);
        check("tp_st_done", state, 2'b10);
        idle();
        check("tp_done_pulse", done, 0);
    endtask

    initial begin
        logic pu, po, ca, re, r;
        logic [WIDTH-1:0] di, dout;

        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        check("rst_occ", occ, 0); check("rst_state", state, 0);

        basic_seq(8'h5A);

        basic_seq(8'hA5);
        step(0, 0, 0, 0, 1, 8'h00, 8'h00);
        check("rearm_idle", state, 2'b00); check("mis_sticky", mismatch, 1);
        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        check("mis_rst", mismatch, 0);

        // Capture-push with simultaneous pop.
        do_push(8'h01); do_push(8'h02);
        step(0, 1, 1, 1, 0, 8'hC3, front());
        check("cp_cnt1", cnt, 1); check("cp_occ2", occ, 2);
        do_pop();
        check("cp_still_trk", state, 2'b01);
        do_pop();
        check("cp_done", done, 1);

        // Overflow, capture while full, push&pop while full, underflow.
        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < DEPTH; i++) do_push(8'(i + 1));
        check("full_occ", occ, 8);
        do_push(8'hEE);
        check("ovf", overflow, 1); check("ovf_occ", occ, 8);
        step(0, 1, 0, 1, 0, 8'h77, 8'h00);
        check("cap_full_idle", state, 2'b00);
        step(0, 1, 1, 0, 0, 8'h66, front());
        check("pp_full_occ", occ, 8); check("pp_full_udf", underflow, 0);
        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        step(0, 1, 1, 0, 0, 8'h99, 8'h00);
        check("udf", underflow, 1); check("udf_occ", occ, 1);

        // Rearm from DONE with occ=5, then capture again.
        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        step(0, 1, 0, 1, 0, 8'h3C, 8'h00);
        for (int i = 0; i < 5; i++) do_push(8'(i + 8'h20));
        do_pop();
        check("ra_done_occ5", occ, 5); check("ra_st", state, 2'b10);
        step(0, 0, 0, 0, 1, 8'h00, 8'h00);
        check("ra_idle", state, 2'b00); check("ra_cnt5", cnt, 5);
        step(0, 1, 0, 1, 0, 8'h4B, 8'h00);
        check("ra_cap_cnt5", cnt, 5); check("ra_cap_occ6", occ, 6);

        // Reset mid-TRACKING.
        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        do_push(8'h10); do_push(8'h20);
        step(0, 1, 0, 1, 0, 8'hF0, 8'h00);
        do_push(8'h30);
        check("mt_occ4", occ, 4); check("mt_cnt2", cnt, 2);
        step(1, 0, 0, 0, 0, 8'h00, 8'h00);
        check("mt_rst_state", state, 0); check("mt_rst_magic", magic_data, 0);
        check("mt_rst_cnt", cnt, 0);
        do_pop();
        check("mt_udf", underflow, 1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            r    = ($urandom_range(0, 199) == 0);
            pu   = ($urandom_range(0, 99) < 55);
            po   = ($urandom_range(0, 99) < 50);
            ca   = ($urandom_range(0, 99) < 15);
            re   = ($urandom_range(0, 99) < 10);
            di   = 8'($urandom);
            dout = ($urandom_range(0, 7) == 0) ? 8'($urandom) : front();
            step(r, pu, po, ca, re, di, dout);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
